// File: rtl/viterbi_core_param_if.sv
// rtl/viterbi_core_param_if.sv - code-symbol in / decoded-bit out bundle for viterbi_core_param
interface viterbi_core_param_if #(
  parameter int SW  = 3,
  parameter int PMW = 8
);
  logic [2*SW-1:0] data_i;
  logic            valid_i;
  logic            sof_i;
  logic            data_o;
  logic            valid_o;
  logic [PMW-1:0]  pm_min_o;

  modport master (
    output data_i, valid_i, sof_i,
    input  data_o, valid_o, pm_min_o
  );

  modport slave (
    input  data_i, valid_i, sof_i,
    output data_o, valid_o, pm_min_o
  );
endinterface

// File: rtl/viterbi_core_param.sv
// rtl/viterbi_core_param.sv - 4-state K=3 (7,5) soft-decision Viterbi decoder, register-exchange survivors
// Define VITERBI_PM_NORM_EN to renormalise metrics every step; otherwise adds saturate.
module viterbi_core_param #(
  parameter int SW       = 3,
  parameter int PMW      = 8,
  parameter int TB_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  viterbi_core_param_if.slave bus
);
  localparam int BMW = SW + 1;
  localparam int FCW = $clog2(TB_DEPTH + 1);
  localparam logic [SW-1:0]       SYM_ONE   = {SW{1'b1}};
  localparam logic [PMW-1:0]      PM_SAT    = {PMW{1'b1}};
  localparam logic [PMW-1:0]      PM_INIT   = PMW'(2 ** (PMW - 2));
  localparam logic [3:0][PMW-1:0] PM_RESET  = {PM_INIT, PM_INIT, PM_INIT, {PMW{1'b0}}};
  localparam logic [FCW-1:0]      FILL_FULL = FCW'(TB_DEPTH);

  function automatic logic [BMW-1:0] sym_dist(input logic e, input logic [SW-1:0] r);
    return {1'b0, (e ? (SYM_ONE - r) : r)};
  endfunction

  function automatic logic [BMW-1:0] branch_metric(input logic e0, input logic e1,
                                                   input logic [2*SW-1:0] d);
    return sym_dist(e0, d[2*SW-1:SW]) + sym_dist(e1, d[SW-1:0]);
  endfunction

  function automatic logic [PMW-1:0] pm_add(input logic [PMW-1:0] pm, input logic [BMW-1:0] bm);
    logic [PMW:0] sum;
    sum = {1'b0, pm} + {{(PMW - BMW + 1){1'b0}}, bm};
    return sum[PMW] ? PM_SAT : sum[PMW-1:0];
  endfunction

  logic [3:0][PMW-1:0]      pm_q, pm_base, pm_new, pm_d;
  logic [3:0][TB_DEPTH-1:0] sv_q, sv_base, sv_d;
  logic [FCW-1:0]           fill_q, fill_base, fill_d;
  logic [PMW-1:0]           pm_min, pm_min_q, pm_min_d;
  logic [1:0]               best;
  logic                     data_q, data_d;
  logic                     valid_q, valid_d;

  // A frame start restarts the trellis from the reset-equivalent state for this very step.
  assign pm_base   = bus.sof_i ? PM_RESET : pm_q;
  assign sv_base   = bus.sof_i ? '0 : sv_q;
  assign fill_base = bus.sof_i ? '0 : fill_q;

  // Predecessors of state ns are the two states whose newest bit equals ns[0].
  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam logic U   = (ns >= 2);
    localparam logic LOW = ((ns % 2) == 1);
    localparam int   PA  = 2 * (ns % 2);
    localparam int   PB  = PA + 1;

    logic [PMW-1:0] cand_a;
    logic [PMW-1:0] cand_b;
    logic           take_b;

    assign cand_a     = pm_add(pm_base[PA], branch_metric(U ^ LOW, U, bus.data_i));
    assign cand_b     = pm_add(pm_base[PB], branch_metric(~(U ^ LOW), ~U, bus.data_i));
    assign take_b     = cand_b < cand_a;
    assign pm_new[ns] = take_b ? cand_b : cand_a;
    assign sv_d[ns]   = {(take_b ? sv_base[PB][TB_DEPTH-2:0] : sv_base[PA][TB_DEPTH-2:0]), U};
  end

  always_comb begin
    pm_min = pm_new[0];
    best   = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (pm_new[s] < pm_min) begin
        pm_min = pm_new[s];
        best   = 2'(s);
      end
    end
  end

`ifdef VITERBI_PM_NORM_EN
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      pm_d[s] = pm_new[s] - pm_min;
    end
  end
  assign pm_min_d = '0;
`else
  assign pm_d     = pm_new;
  assign pm_min_d = pm_min;
`endif

  assign fill_d  = (fill_base == FILL_FULL) ? fill_base : fill_base + FCW'(1);
  assign valid_d = bus.valid_i && (fill_d == FILL_FULL);
  assign data_d  = sv_d[best][TB_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q     <= PM_RESET;
      sv_q     <= '0;
      fill_q   <= '0;
      pm_min_q <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (bus.valid_i) begin
        pm_q     <= pm_d;
        sv_q     <= sv_d;
        fill_q   <= fill_d;
        pm_min_q <= pm_min_d;
        data_q   <= data_d;
      end
    end
  end

  assign bus.data_o   = data_q;
  assign bus.valid_o  = valid_q;
  assign bus.pm_min_o = pm_min_q;
endmodule

// File: doc/viterbi_core_param.md
VITERBI_CORE_PARAM -- requirements
Module: viterbi_core_param

Interface
REQ-001 SHALL have parameter SW, default 3, soft-decision bits per code symbol (1..6; SW=1 is hard decision).
REQ-002 SHALL have parameter PMW, default 8, path-metric width in bits (>= SW+4).
REQ-003 SHALL have parameter TB_DEPTH, default 16, survivor register depth (4..64).
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have port data_i, input, 2*SW bits, code-symbol pair: [2*SW-1:SW] = G0 symbol, [SW-1:0] = G1 symbol.
REQ-007 SHALL have port valid_i, input, 1 bit, data_i qualifier; one trellis step per cycle with valid_i=1.
REQ-008 SHALL have port sof_i, input, 1 bit, start of frame; sampled only when valid_i=1.
REQ-009 SHALL have port data_o, input-derived output, 1 bit, decoded bit.
REQ-010 SHALL have port valid_o, output, 1 bit, data_o qualifier, one-cycle pulse per accepted step once filled.
REQ-011 SHALL have port pm_min_o, output, PMW bits, minimum of the four current path metrics.

Function
REQ-012 SHALL decode the rate-1/2, K=3 code with generators 7,5 (octal); 4 states, next state = {u, s[1]}, trellis edges s0->s0/s2, s1->s0/s2, s2->s1/s3, s3->s1/s3.
REQ-013 SHALL treat each soft symbol as unsigned: 0 = confident '0', 2^SW-1 = confident '1'.
REQ-014 SHALL compute each branch metric as |E0 - r0| + |E1 - r1|, where E = 0 or 2^SW-1 per expected bit; width SW+1, combinational.
REQ-015 SHALL, per accepted step, perform add-compare-select for all 4 states; on equal candidates select the lower-numbered predecessor.
REQ-016 SHALL keep per state a TB_DEPTH-bit survivor register; on step, new = {winning predecessor register[TB_DEPTH-2:0], decided bit u = s'[1]}.
REQ-017 SHALL select best state as the one with minimum new metric; ties go to the lowest index.
REQ-018 SHALL register data_o = MSB of the best state's new survivor register, with valid_o=1 exactly one clock after the accepting edge.
REQ-019 SHALL keep a fill counter (0..TB_DEPTH, saturating), incremented per step; valid_o asserted only for steps where the counter, after increment, equals TB_DEPTH.
REQ-020 SHALL, when sof_i=1 with valid_i=1, process that symbol from initial metrics s0=0, s1..s3=2^(PMW-2), survivors cleared, and fill counter restarted so this step counts as 1.
REQ-021 SHALL hold all state and drive valid_o=0 on cycles with valid_i=0; data_o holds its last value.
REQ-022 SHALL update pm_min_o on the same edge as the metrics.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set metrics to s0=0, s1..s3=2^(PMW-2), survivors=0, fill counter=0, data_o=0, valid_o=0, pm_min_o=0.
REQ-024 SHALL discard any step in flight when reset asserts mid-frame; first step after release is treated as frame start regardless of sof_i.

Configuration
REQ-025 SHALL, with VITERBI_PM_NORM_EN defined, subtract the minimum new metric from all four new metrics every step (pm_min_o therefore always 0).
REQ-026 SHALL, without VITERBI_PM_NORM_EN, saturate every add at 2^PMW-1 and perform no subtraction.

Verification
REQ-027 SHALL cover reset: rst_n=0 mid-stream -> valid_o=0, data_o=0, pm_min_o=0 immediately, without a clock edge.
REQ-028 SHALL cover clean decode: SW=3, D=16, sof on first of 40 encoded symbols of message 1011001110001011... with hard-ideal values 0/7 -> valid_o first high on clock after 16th step, data_o reproduces message from bit 0.
REQ-029 SHALL cover error correction: same stream with one symbol per 8 steps flipped 7->0 -> decoded output equals message, zero bit errors.
REQ-030 SHALL cover bubbles: valid_i deasserted on random cycles (50%) -> identical output sequence to REQ-028, valid_o never high on idle-following cycles without a step.
REQ-031 SHALL cover sof mid-stream: sof_i at step 25 -> no valid_o for next 15 steps, then new frame decoded from its first bit.
REQ-032 SHALL cover metric boundary: 300 all-erroneous symbols (r=3,4) -> with VITERBI_PM_NORM_EN min metric stays 0; without it metrics saturate at 255 and never wrap.
